dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_arbiter_rr.sv | 22 ++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester ports and memory pins of the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  gnt;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wr;
    logic                  mem_rd;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, gnt, busy, mem_addr, mem_wdata, mem_wr, mem_rd
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, gnt, busy, mem_addr, mem_wdata, mem_wr, mem_rd
    );
endinterface

// File: rtl/dmem_arbiter_rr.sv
// rtl/dmem_arbiter_rr.sv - two-way round-robin winner selection
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic       winner,
    output logic       valid
);

    assign valid = |req;

    // Contention goes to the port that was not granted last; otherwise the lone requester wins.
    always_comb begin
        winner = PORT_CPU;
        if (req == 2'b11)
            winner = ~pointer;
        else if (req[1])
            winner = PORT_AUX;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises two requesters onto the single-port data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_t                state;
    logic                  ptr;
    logic                  we_q;
    logic                  gnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic [1:0]            req_vec;
    logic                  win;
    logic                  win_valid;
    logic                  grant;

    assign req_vec = {bus.req1, bus.req0};
    // Requests are only looked at in IDLE, so a port dropping req during DONE is never seen as new work.
    assign grant   = (state == IDLE) && win_valid;

    rr_arbiter2 u_rr (
        .req     (req_vec),
        .pointer (ptr),
        .winner  (win),
        .valid   (win_valid)
    );

    // Sequencer: one access takes IDLE -> ACCESS -> DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (win_valid) state <= ACCESS;
                ACCESS:  state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the winner's request into the memory-facing registers and advance the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gnt_q   <= PORT_CPU;
            ptr     <= PORT_AUX;
        end else if (grant) begin
            addr_q  <= (win == PORT_AUX) ? bus.addr1  : bus.addr0;
            wdata_q <= (win == PORT_AUX) ? bus.wdata1 : bus.wdata0;
            we_q    <= (win == PORT_AUX) ? bus.we1    : bus.we0;
            gnt_q   <= win;
            ptr     <= win;
        end
    end

    // Ack pulse for the DONE cycle and read data captured on the edge leaving ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ack0_q <= (state == ACCESS) && (gnt_q == PORT_CPU);
            ack1_q <= (state == ACCESS) && (gnt_q == PORT_AUX);
            if ((state == ACCESS) && !we_q) begin
                if (gnt_q == PORT_CPU)
                    rdata0_q <= bus.mem_rdata;
                else
                    rdata1_q <= bus.mem_rdata;
            end
        end
    end

    // Strobes decode straight from state so an asynchronous reset removes them before the next edge.
    assign bus.mem_wr    = (state == ACCESS) &&  we_q;
    assign bus.mem_rd    = (state == ACCESS) && !we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    dmem_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    dmem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: combinational read, tri-stated when not reading, write on the edge.
    assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (bus.mem_wr)
            mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // The two strobes must never overlap.
    always @(negedge clk) begin
        checks++;
        if (bus.mem_rd && bus.mem_wr) begin
            errors++;
            $display("FAIL strobe_overlap: mem_rd=%b mem_wr=%b required not both 1", bus.mem_rd, bus.mem_wr);
        end
    end

    task automatic clear_reqs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.we0  = 1'b0; bus.we1  = 1'b0;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00;
        bus.wdata0 = 16'h0000; bus.wdata1 = 16'h0000;
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({bus.ack0, bus.ack1, bus.mem_wr, bus.mem_rd, bus.gnt, bus.busy} !== 6'b0) begin
            errors++;
            $display("FAIL %s_ctrl: ack0/ack1/wr/rd/gnt/busy=%b required 000000", tag,
                     {bus.ack0, bus.ack1, bus.mem_wr, bus.mem_rd, bus.gnt, bus.busy});
        end
        checks++;
        if ({bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata} !== 56'h0) begin
            errors++;
            $display("FAIL %s_data: rdata0=%h rdata1=%h mem_addr=%h mem_wdata=%h required all 0", tag,
                     bus.rdata0, bus.rdata1, bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_reqs();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        mem[1] = 16'h0053;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        @(negedge clk);
        checks++;
        if ({bus.mem_rd, bus.mem_wr, bus.busy, bus.ack0} !== 4'b1010) begin
            errors++;
            $display("FAIL read_access: rd/wr/busy/ack0=%b required 1010", {bus.mem_rd, bus.mem_wr, bus.busy, bus.ack0});
        end
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.mem_rd} !== 3'b100 || bus.rdata0 !== 16'h0053) begin
            errors++;
            $display("FAIL read_ack: ack0/ack1/rd=%b rdata0=%h required 100 0053", {bus.ack0, bus.ack1, bus.mem_rd}, bus.rdata0);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.busy} !== 3'b000 || bus.rdata0 !== 16'h0053) begin
            errors++;
            $display("FAIL read_hold: ack0/ack1/busy=%b rdata0=%h required 000 0053", {bus.ack0, bus.ack1, bus.busy}, bus.rdata0);
        end
    endtask

    task automatic test_write_readback();
        int wr_cycles;
        wr_cycles = 0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_wr) wr_cycles++;
            if (i == 1) begin
                checks++;
                if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL write_ack: ack1=%b ack0=%b gnt=%b required 1 0 1", bus.ack1, bus.ack0, bus.gnt);
                end
                bus.req1 = 1'b0;
            end
        end
        checks++;
        if (wr_cycles != 1 || mem[8'h20] !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_commit: wr_cycles=%0d mem=%h required 1 BEEF", wr_cycles, mem[8'h20]);
        end
        bus.req1 = 1'b1; bus.we1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ack1 !== 1'b1 || bus.rdata1 !== 16'hBEEF) begin
            errors++;
            $display("FAIL readback: ack1=%b rdata1=%h required 1 BEEF", bus.ack1, bus.rdata1);
        end
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        mem[5] = 16'h0090; mem[9] = 16'h0029;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h05;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h09;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0 || bus.rdata0 !== 16'h0090) begin
            errors++;
            $display("FAIL contention_first: ack0=%b ack1=%b rdata0=%h required 1 0 0090", bus.ack0, bus.ack1, bus.rdata0);
        end
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.rdata1 !== 16'h0029) begin
            errors++;
            $display("FAIL contention_second: ack1=%b ack0=%b rdata1=%h required 1 0 0029", bus.ack1, bus.ack0, bus.rdata1);
        end
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int n_acks;
        logic exp_port;
        n_acks = 0;
        exp_port = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h05;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h09;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                n_acks++;
                checks++;
                if ({bus.ack1, bus.ack0} !== (exp_port ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL fairness_order: cycle %0d ack1/ack0=%b required port %0d", c, {bus.ack1, bus.ack0}, exp_port);
                end
                exp_port = ~exp_port;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        checks++;
        if (n_acks != 6) begin
            errors++;
            $display("FAIL fairness_count: acks=%0d required 6", n_acks);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_done_request();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
        @(negedge clk);
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.mem_rd, bus.ack1} !== 3'b000) begin
            errors++;
            $display("FAIL done_req_idle: busy/rd/ack1=%b required 000", {bus.busy, bus.mem_rd, bus.ack1});
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.mem_rd, bus.gnt} !== 3'b111 || bus.mem_addr !== 8'h20) begin
            errors++;
            $display("FAIL done_req_grant: busy/rd/gnt=%b addr=%h required 111 20", {bus.busy, bus.mem_rd, bus.gnt}, bus.mem_addr);
        end
        @(negedge clk);
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        mem[3] = 16'h0016;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h03; bus.wdata0 = 16'h1234;
        @(negedge clk);
        checks++;
        if (bus.mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL midwr_access: mem_wr=%b required 1", bus.mem_wr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL midwr_async: mem_wr=%b required 0", bus.mem_wr);
        end
        @(negedge clk);
        check_reset_values("midwr");
        checks++;
        if (mem[3] !== 16'h0016) begin
            errors++;
            $display("FAIL midwr_mem: mem[3]=%h required 0016", mem[3]);
        end
        rst = 1'b0;
        bus.we0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 16'h0016) begin
            errors++;
            $display("FAIL midwr_readback: ack0=%b rdata0=%h required 1 0016", bus.ack0, bus.rdata0);
        end
        rst = 1'b1;
        #1;
        check_reset_values("middone");
        rst = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    // Random traffic against a transaction-level model: one access per 3 cycles, round-robin on contention.
    task automatic test_random();
        logic       pend [2];
        logic       we_r [2];
        logic [7:0] ad_r [2];
        logic [15:0] wd_r [2];
        logic [15:0] exp_rd [2];
        logic       mptr;
        int         next_ok, ack_c, ack_p, n_acks;
        logic       ack_rd;
        logic [15:0] ack_dat;
        logic       w;

        rst = 1'b1;
        clear_reqs();
        for (int a = 0; a < 16; a++) begin
            mem[a] = 16'($urandom);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = mem[a];
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; we_r[p] = 1'b0; ad_r[p] = 8'h00; wd_r[p] = 16'h0000; exp_rd[p] = 16'h0000;
        end
        mptr = 1'b1; next_ok = 0; ack_c = -1; ack_p = 0; ack_rd = 1'b0; ack_dat = 16'h0000; n_acks = 0;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (bus.ack0 !== (c == ack_c && ack_p == 0) || bus.ack1 !== (c == ack_c && ack_p == 1)) begin
                errors++;
                $display("FAIL rand_ack: cycle %0d ack0=%b ack1=%b required port %0d at cycle %0d", c, bus.ack0, bus.ack1, ack_p, ack_c);
            end
            checks++;
            if (bus.busy !== (c == ack_c || c == ack_c - 1)) begin
                errors++;
                $display("FAIL rand_busy: cycle %0d busy=%b required %b", c, bus.busy, (c == ack_c || c == ack_c - 1));
            end
            if (c == ack_c) begin
                n_acks++;
                if (ack_rd) exp_rd[ack_p] = ack_dat;
                pend[ack_p] = 1'b0;
                checks++;
                if (bus.gnt !== ack_p[0]) begin
                    errors++;
                    $display("FAIL rand_gnt: cycle %0d gnt=%b required %0d", c, bus.gnt, ack_p);
                end
            end
            checks++;
            if (bus.rdata0 !== exp_rd[0] || bus.rdata1 !== exp_rd[1]) begin
                errors++;
                $display("FAIL rand_rdata: cycle %0d rdata0=%h rdata1=%h required %h %h", c, bus.rdata0, bus.rdata1, exp_rd[0], exp_rd[1]);
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    we_r[p] = 1'($urandom_range(0, 1));
                    ad_r[p] = 8'($urandom_range(0, 15));
                    wd_r[p] = 16'($urandom);
                end
            end
            bus.req0 = pend[0]; bus.we0 = we_r[0]; bus.addr0 = ad_r[0]; bus.wdata0 = wd_r[0];
            bus.req1 = pend[1]; bus.we1 = we_r[1]; bus.addr1 = ad_r[1]; bus.wdata1 = wd_r[1];
            if (c >= next_ok && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? ~mptr : pend[1];
                mptr = w;
                ack_p = int'(w);
                ack_c = c + 2;
                next_ok = c + 3;
                ack_rd = !we_r[w];
                if (we_r[w]) ref_mem[ad_r[w]] = wd_r[w];
                else ack_dat = ref_mem[ad_r[w]];
            end
        end
        clear_reqs();
        repeat (4) @(negedge clk);
        checks++;
        if (n_acks < 100) begin
            errors++;
            $display("FAIL rand_throughput: acks=%0d required at least 100", n_acks);
        end
        for (int a = 0; a < 16; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin
                errors++;
                $display("FAIL rand_mem: addr %0d mem=%h required %h", a, mem[a], ref_mem[a]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int a = 0; a < 256; a++) mem[a] = 16'(a);
        test_reset();
        test_single_read();
        test_write_readback();
        test_contention();
        test_fairness();
        test_done_request();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
